// File: rtl/ask_frame_scheduler.sv
// Frame sequencer for the ASK modulator: buffers payload bytes and serialises
// preamble + payload + idle gap, MSB-first, one symbol every BIT_CYCLES clocks.
module ask_frame_scheduler #(
    parameter int unsigned BIT_CYCLES = 40,
    parameter logic [7:0]  PREAMBLE   = 8'hAA,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_BITS   = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       data_out,
    output logic       bit_tick,
    output logic       tx_busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);
    localparam logic [3:0]    LAST_GAP = 4'(GAP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        PAY,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [3:0]    gap_q, gap_d;
    logic [7:0]    rem_q, rem_d;
    logic [7:0]    shift_q, shift_d;
    logic          data_q, data_d;
    logic          tick_q, tick_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          under_q, under_d;

    // Payload FIFO; the extra pointer MSB separates full from empty.
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        full, empty, push, pop;
    logic [7:0]  head;
    logic        sym_end;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign sym_end  = (cyc_q == LAST_CYC);

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            bit_idx_q <= '0;
            gap_q     <= '0;
            rem_q     <= '0;
            shift_q   <= '0;
            data_q    <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            under_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_idx_q <= bit_idx_d;
            gap_q     <= gap_d;
            rem_q     <= rem_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            tick_q    <= tick_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            under_q   <= under_d;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        bit_idx_d = bit_idx_q;
        gap_d     = gap_q;
        rem_d     = rem_q;
        shift_d   = shift_q;
        data_d    = data_q;
        tick_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        under_d   = 1'b0;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                data_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    state_d   = PRE;
                    rem_d     = frame_len;
                    shift_d   = PREAMBLE;
                    bit_idx_d = 3'd7;
                    cyc_d     = '0;
                    data_d    = PREAMBLE[7];
                    tick_d    = 1'b1;
                    busy_d    = 1'b1;
                end
            end

            PRE, PAY: begin
                if (!sym_end) begin
                    cyc_d = cyc_q + 1'b1;
                end else begin
                    cyc_d  = '0;
                    tick_d = 1'b1;
                    if (bit_idx_q != 3'd0) begin
                        bit_idx_d = bit_idx_q - 3'd1;
                        shift_d   = {shift_q[6:0], 1'b0};
                        data_d    = shift_q[6];
                    end else if (rem_q != 8'd0 && !empty) begin
                        // Byte boundary: pop the next byte with no inter-byte gap.
                        pop       = 1'b1;
                        shift_d   = head;
                        data_d    = head[7];
                        rem_d     = rem_q - 8'd1;
                        bit_idx_d = 3'd7;
                        state_d   = PAY;
                    end else begin
                        under_d = (rem_q != 8'd0);
                        state_d = GAP;
                        gap_d   = '0;
                        data_d  = 1'b0;
                    end
                end
            end

            GAP: begin
                data_d = 1'b0;
                if (!sym_end) begin
                    cyc_d = cyc_q + 1'b1;
                end else begin
                    cyc_d = '0;
                    if (gap_q == LAST_GAP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        gap_d  = gap_q + 4'd1;
                        tick_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_out   = data_q;
    assign bit_tick   = tick_q;
    assign tx_busy    = busy_q;
    assign frame_done = done_q;
    assign underrun   = under_q;

endmodule

// File: tb/tb_ask_frame_scheduler.sv
// Bench for ask_frame_scheduler: queue-based frame model compared every cycle,
// plus directed frames with hand-computed bit patterns and durations.
module tb_ask_frame_scheduler;

    localparam int unsigned BC    = 40;
    localparam logic [7:0]  PRE   = 8'hAA;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned GAPN  = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] frame_len = 8'd0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready, data_out, bit_tick, tx_busy, frame_done, underrun;

    int checks = 0;
    int errors = 0;

    ask_frame_scheduler #(
        .BIT_CYCLES (BC),
        .PREAMBLE   (PRE),
        .FIFO_DEPTH (DEPTH),
        .GAP_BITS   (GAPN)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .frame_len  (frame_len),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_out   (data_out),
        .bit_tick   (bit_tick),
        .tx_busy    (tx_busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check1(input string nm, input logic got, input logic expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, expv, $time);
        end
    endtask

    task automatic check_int(input string nm, input longint got, input longint expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, expv, $time);
        end
    endtask

    task automatic check_vec(input string nm, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, expv, $time);
        end
    endtask

    // Model: a frame is a queue of symbols; a byte is appended whenever the queue runs dry.
    logic       m_busy = 1'b0, m_gap = 1'b0;
    int         m_pos = 0, m_rem = 0;
    logic       m_syms[$];
    logic [7:0] m_fifo[$];
    logic       m_push;
    logic [7:0] m_byte;
    logic [7:0] m_pre = PRE;
    logic       exp_data = 1'b0, exp_tick = 1'b0, exp_busy = 1'b0;
    logic       exp_done = 1'b0, exp_under = 1'b0, exp_ready = 1'b1;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_busy = 1'b0; m_gap = 1'b0; m_pos = 0; m_rem = 0;
            m_syms.delete(); m_fifo.delete();
            exp_data = 1'b0; exp_tick = 1'b0; exp_busy = 1'b0;
            exp_done = 1'b0; exp_under = 1'b0; exp_ready = 1'b1;
        end else begin
            m_push = in_valid && (m_fifo.size() < DEPTH);
            exp_tick = 1'b0; exp_done = 1'b0; exp_under = 1'b0;
            if (!m_busy) begin
                exp_data = 1'b0; exp_busy = 1'b0;
                if (start) begin
                    m_busy = 1'b1; m_gap = 1'b0; m_rem = frame_len; m_pos = 0;
                    m_syms.delete();
                    for (int i = 7; i >= 0; i--) m_syms.push_back(m_pre[i]);
                    exp_tick = 1'b1; exp_busy = 1'b1; exp_data = m_syms[0];
                end
            end else begin
                m_pos++;
                if (m_pos % BC == 0) begin
                    void'(m_syms.pop_front());
                    if (m_syms.size() == 0) begin
                        if (m_gap) begin
                            m_busy = 1'b0; exp_done = 1'b1; exp_busy = 1'b0;
                        end else if (m_rem > 0 && m_fifo.size() > 0) begin
                            m_byte = m_fifo.pop_front();
                            m_rem--;
                            for (int i = 7; i >= 0; i--) m_syms.push_back(m_byte[i]);
                        end else begin
                            if (m_rem > 0) exp_under = 1'b1;
                            m_gap = 1'b1;
                            for (int i = 0; i < GAPN; i++) m_syms.push_back(1'b0);
                        end
                    end
                    if (m_busy) begin
                        exp_tick = 1'b1; exp_data = m_syms[0];
                    end else begin
                        exp_data = 1'b0;
                    end
                end
            end
            if (m_push) m_fifo.push_back(in_data);
            exp_ready = (m_fifo.size() < DEPTH);
        end
    end

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            check1("data_out", data_out, exp_data);
            check1("bit_tick", bit_tick, exp_tick);
            check1("tx_busy", tx_busy, exp_busy);
            check1("frame_done", frame_done, exp_done);
            check1("underrun", underrun, exp_under);
            check1("in_ready", in_ready, exp_ready);
        end
    end

    // Frame monitor for the directed literal checks.
    int   cyc = 0;
    int   first_cyc = -1, done_cyc = -1, under_cyc = -1;
    int   ticks = 0, done_n = 0, under_n = 0;
    logic got_bits[$];

    always @(negedge sys_clk) begin
        cyc++;
        if (!sys_rst) begin
            if (bit_tick) begin
                if (first_cyc < 0) first_cyc = cyc;
                got_bits.push_back(data_out);
                ticks++;
            end
            if (underrun) begin under_n++; under_cyc = cyc; end
            if (frame_done) begin done_n++; done_cyc = cyc; end
        end
    end

    task automatic clear_stats();
        first_cyc = -1; done_cyc = -1; under_cyc = -1;
        ticks = 0; done_n = 0; under_n = 0;
        got_bits.delete();
    endtask

    function automatic logic [63:0] packed_bits();
        logic [63:0] v = '0;
        foreach (got_bits[i]) v = {v[62:0], got_bits[i]};
        return v;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1; in_data = b;
        while (!in_ready && n < 2000) begin @(posedge sys_clk); #2; n++; end
        if (!in_ready) begin errors++; $display("FAIL push_timeout: in_ready stayed 0"); end
        @(posedge sys_clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] len);
        frame_len = len; start = 1'b1;
        @(posedge sys_clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!frame_done && n < 5000) begin @(posedge sys_clk); #2; n++; end
        checks++;
        if (!frame_done) begin errors++; $display("FAIL done_timeout: frame_done 0 expected 1"); end
    endtask

    task automatic check_frame(input string nm, input int nbits, input logic [63:0] bits,
                               input int dur, input int unders);
        check_int({nm, "_ticks"}, ticks, nbits);
        check_vec({nm, "_bits"}, packed_bits(), bits);
        check_int({nm, "_duration"}, done_cyc - first_cyc, dur);
        check_int({nm, "_underruns"}, under_n, unders);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge sys_clk);
        #3;
        check1("rst_data_out", data_out, 1'b0);
        check1("rst_bit_tick", bit_tick, 1'b0);
        check1("rst_tx_busy", tx_busy, 1'b0);
        check1("rst_frame_done", frame_done, 1'b0);
        check1("rst_underrun", underrun, 1'b0);
        @(posedge sys_clk); #2;
        sys_rst = 1'b0;
        @(posedge sys_clk); #2;
        check1("rst_in_ready", in_ready, 1'b1);

        // One byte frame
        push_byte(8'hC3);
        clear_stats();
        start_frame(8'd1);
        wait_done();
        @(negedge sys_clk); #1;
        check_frame("len1", 18, {46'd0, 8'hAA, 8'hC3, 2'b00}, 720, 0);

        // Empty frame with a restart attempt mid-frame; FIFO byte must survive
        push_byte(8'h5A);
        clear_stats();
        start_frame(8'd0);
        repeat (100) @(posedge sys_clk);
        #2;
        start_frame(8'd3);
        wait_done();
        frame_len = 8'd1; start = 1'b1;
        @(negedge sys_clk); #1;
        check_frame("len0", 10, {54'd0, 8'hAA, 2'b00}, 400, 0);
        clear_stats();
        @(posedge sys_clk); #2;
        start = 1'b0;
        check1("b2b_bit_tick", bit_tick, 1'b1);
        check1("b2b_tx_busy", tx_busy, 1'b1);
        check1("b2b_data_out", data_out, PRE[7]);
        wait_done();
        @(negedge sys_clk); #1;
        check_frame("b2b", 18, {46'd0, 8'hAA, 8'h5A, 2'b00}, 720, 0);

        // FIFO full backpressure and a five-byte frame
        @(posedge sys_clk); #2;
        push_byte(8'h81);
        push_byte(8'h7E);
        push_byte(8'hF0);
        push_byte(8'h0F);
        check1("full_in_ready", in_ready, 1'b0);
        in_valid = 1'b1; in_data = 8'hA5;
        repeat (3) begin @(posedge sys_clk); #2; end
        check1("held_in_ready", in_ready, 1'b0);
        clear_stats();
        start_frame(8'd5);
        begin
            int n = 0;
            while (!in_ready && n < 1000) begin @(posedge sys_clk); #2; n++; end
            check1("slot_freed", in_ready, 1'b1);
        end
        @(posedge sys_clk); #2;
        in_valid = 1'b0;
        wait_done();
        @(negedge sys_clk); #1;
        check_frame("len5", 50, {14'd0, 8'hAA, 8'h81, 8'h7E, 8'hF0, 8'h0F, 8'hA5, 2'b00}, 2000, 0);

        // Underrun: three bytes requested, one supplied
        @(posedge sys_clk); #2;
        push_byte(8'h3C);
        clear_stats();
        start_frame(8'd3);
        wait_done();
        @(negedge sys_clk); #1;
        check_frame("under", 18, {46'd0, 8'hAA, 8'h3C, 2'b00}, 720, 1);
        check_int("under_offset", under_cyc - first_cyc, 640);

        // Asynchronous reset in the middle of a payload byte
        @(posedge sys_clk); #2;
        push_byte(8'hE7);
        push_byte(8'h18);
        clear_stats();
        start_frame(8'd2);
        repeat (420) @(posedge sys_clk);
        #7;
        check1("pre_rst_data_out", data_out, 1'b1);
        check1("pre_rst_tx_busy", tx_busy, 1'b1);
        sys_rst = 1'b1;
        #1;
        check1("arst_data_out", data_out, 1'b0);
        check1("arst_bit_tick", bit_tick, 1'b0);
        check1("arst_tx_busy", tx_busy, 1'b0);
        check1("arst_frame_done", frame_done, 1'b0);
        check1("arst_underrun", underrun, 1'b0);
        repeat (2) @(posedge sys_clk);
        #2;
        sys_rst = 1'b0;
        @(posedge sys_clk); #2;
        check1("arst_in_ready", in_ready, 1'b1);
        clear_stats();
        repeat (700) @(posedge sys_clk);
        #2;
        check_int("arst_no_done", done_n, 0);
        check1("arst_idle_busy", tx_busy, 1'b0);
        // FIFO must be empty after reset: a one-byte frame now underruns
        clear_stats();
        start_frame(8'd1);
        wait_done();
        @(negedge sys_clk); #1;
        check_frame("post_rst", 10, {54'd0, 8'hAA, 2'b00}, 400, 1);

        repeat (3) @(posedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ask_frame_scheduler.md
Name: ask_frame_scheduler

Overview:
- Sequences the ASK modulator's `data_in` bit stream: buffers payload bytes, wraps them in a frame and serialises MSB-first.
- Frame format: fixed preamble byte, then N payload bytes, then an idle gap.
- Each bit is held for a programmable number of `sys_clk` cycles.
- Sits between the byte source (UART/CPU) and the ASK modulator; `data_out` drives the modulator's `data_in` directly.

Parameters:
- BIT_CYCLES, 40, `sys_clk` cycles per symbol (40 × 20 ns = 800 ns at 50 MHz); legal range 2..65535.
- PREAMBLE, 8'hAA, preamble byte sent MSB-first at the start of every frame.
- FIFO_DEPTH, 4, payload byte buffer depth; must be a power of two, ≥2.
- GAP_BITS, 2, number of '0' symbols appended after the last payload bit; range 1..15.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame request; honoured only in IDLE.
- frame_len  in  8  payload byte count, latched on an accepted start; 0 is legal.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO not full; a byte is written when in_valid & in_ready.
- data_out  out  1  serial symbol to the modulator (1 = carrier on).
- bit_tick  out  1  one-cycle pulse in the first cycle of every symbol, including gap symbols.
- tx_busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at normal or aborted frame end.
- underrun  out  1  one-cycle pulse when a payload byte is needed but the FIFO is empty.

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE; FIFO empty.
  - data_out = 0, bit_tick = 0, tx_busy = 0, frame_done = 0, underrun = 0.
  - in_ready = 1 once reset is released.
  - Reset mid-frame aborts immediately: no frame_done, and FIFO contents are discarded.
- FIFO:
  - Writes are accepted in any FSM state.
  - in_ready = !full, derived from registered pointers.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - An extra pointer bit distinguishes full from empty.
- Symbol timer:
  - cyc_cnt counts 0..BIT_CYCLES-1.
  - bit_tick = 1 when cyc_cnt == 0 in any non-IDLE state.
  - A symbol ends when cyc_cnt == BIT_CYCLES-1.
  - bit_idx counts 7..0 within a byte.
- FSM states and transitions:
  - IDLE: data_out = 0.
    - If start = 1 at edge N: latch frame_len into a remaining-byte count and go to PRE.
    - From cycle N+1: data_out = PREAMBLE[7], bit_tick = 1, tx_busy = 1.
    - start is ignored while in any non-IDLE state.
  - PRE: shifts PREAMBLE MSB-first, 8 symbols.
    - At the end of the last symbol: if remaining == 0, go to GAP.
    - Otherwise, if the FIFO is not empty, pop (same cycle) into the shift register, decrement remaining, go to PAY.
    - If the FIFO is empty, pulse underrun and go to GAP (abort).
  - PAY: shifts the byte MSB-first.
    - At the end of bit 0, apply the same test as the end of PRE: next byte, GAP, or underrun → GAP.
    - Consecutive bytes have no inter-byte gap.
  - GAP: data_out = 0 for GAP_BITS symbols.
    - In the final cycle of the last symbol, go to IDLE.
    - frame_done = 1 and tx_busy = 0 in the first IDLE cycle.
    - A start in that same cycle is honoured.
- Frame length: total cycles from the first bit_tick to frame_done is (8 + 8·frame_len + GAP_BITS) · BIT_CYCLES.
- Output timing: all outputs are registered; data_out changes only on symbol boundaries.
- Underrun pulse: coincides with the cycle in which GAP symbol 0 begins.

Test Plan:
- Reset, then start with frame_len = 1 and byte 8'hC3 pre-loaded:
  - data_out = 1,0,1,0,1,0,1,0, 1,1,0,0,0,0,1,1, 0,0, each held 40 cycles.
  - 18 bit_ticks.
  - frame_done exactly 720 cycles after the first bit_tick; underrun never set.
- frame_len = 0:
  - Preamble followed by 2 gap symbols.
  - frame_done after 400 cycles; FIFO untouched.
- Push 5 bytes back-to-back with FIFO_DEPTH = 4:
  - in_ready falls after the 4th write; the 5th byte is held off.
  - Start with frame_len = 5, feeding the 5th byte once the first pop frees a slot: all 40 payload bits are correct, with no gap between bytes.
- Underrun: frame_len = 3 with only 1 byte supplied.
  - underrun pulses at the end of byte 1.
  - data_out = 0 for 2 gap symbols.
  - frame_done at (8 + 8 + 2) · 40 = 720 cycles.
- Start re-asserted mid-frame: ignored, and the frame timing is unchanged.
- Start in the frame_done cycle begins a new preamble the next cycle.
- Assert sys_rst asynchronously mid-PAY (between clock edges):
  - All outputs drop to their reset values immediately.
  - in_ready = 1 once reset is released, and the FIFO is empty.
  - No frame_done pulse is produced.
